// File: rtl/bus_out_pkg.sv
// Shared definitions for the buffered bus output port: serializer state
// encoding and configuration helpers.
package bus_out_pkg;

  // Serializer states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Number of bytes carried by one bus word
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Legal configuration: whole bytes per word, power-of-two depth of at least 2
  function automatic bit cfg_ok(input int data_width, input int depth);
    return (data_width >= 8) && ((data_width % 8) == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/bus_out_fifo_if.sv
// Bus-side and byte-stream-side signals of the buffered output port.
//
// Byte stream handshake: a byte transfers on every rising clk edge where
// tx_valid && tx_ready. Once tx_valid is high it stays high, and tx_data
// stays unchanged, until that transfer happens; tx_valid never depends on
// tx_ready.
interface bus_out_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  busy;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;

  // The port itself
  modport slave (
    input  wr_en, wr_data, tx_ready,
    output full, empty, count, overflow, busy, tx_valid, tx_data
  );

  // The bus controller / UART side driving the port
  modport master (
    output wr_en, wr_data, tx_ready,
    input  full, empty, count, overflow, busy, tx_valid, tx_data
  );
endinterface

// File: rtl/bus_out_fifo_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a sticky overflow
// flag. Read data is the head entry, read asynchronously from distributed RAM.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [CW-1:0]         count_next;

  // full/empty are the registered state at the start of the cycle, so a
  // write while full is dropped even if a pop happens on the same edge
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy: +1 on write, -1 on pop, unchanged on both or neither
  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (wr_ok && !s_reset && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags and sticky overflow
  always_ff @(posedge clk) begin
    if (s_reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/bus_out_fifo.sv
// Buffered processor-bus output port: queues bus words and serialises each
// one into bytes on a valid/ready stream toward the UART transmitter.
module bus_out_fifo
  import bus_out_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int LSB_FIRST  = 0
) (
  input  logic           clk,
  input  logic           s_reset,
  input  logic           flush,
  bus_out_fifo_if.slave  bus,
  output logic [0:0]     dbg_state
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  if (!cfg_ok(DATA_WIDTH, DEPTH)) begin : g_bad_cfg
    $error("bus_out_fifo: DATA_WIDTH must be a multiple of 8 (>=8) and DEPTH a power of two (>=2)");
  end

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] sreg_shifted;
  logic [DATA_WIDTH-1:0] head;
  logic [IW-1:0]         idx;
  logic [7:0]            tx_data_q;
  logic                  accept;
  logic                  last_byte;
  logic                  pop;

  // Byte presented on the stream for a given shift-register image
  function automatic logic [7:0] pick(input logic [DATA_WIDTH-1:0] w);
    if (LSB_FIRST != 0) return w[7:0];
    else                return w[DATA_WIDTH-1 -: 8];
  endfunction

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .s_reset  (s_reset),
    .flush    (flush),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (bus.full),
    .empty    (bus.empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  // tx_valid is exactly the SEND state, so it never depends on tx_ready
  assign accept    = (state == ST_SEND) && bus.tx_ready;
  assign last_byte = (idx == IW'(BPW - 1));
  // Pop when idle, or on the edge the last byte leaves, so words run back to back
  assign pop       = !bus.empty && ((state == ST_IDLE) || (accept && last_byte));

  // Move the next byte into the presentation position
  assign sreg_shifted = (LSB_FIRST != 0) ? (sreg >> 8) : (sreg << 8);

  assign bus.tx_valid = (state == ST_SEND);
  assign bus.busy     = (state == ST_SEND);
  assign bus.tx_data  = tx_data_q;
  assign dbg_state    = state;

  // Serializer FSM: load a word, step through its bytes on each accept
  always_ff @(posedge clk) begin
    if (s_reset || flush) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      idx       <= '0;
      tx_data_q <= 8'h00;
    end else if (pop) begin
      state     <= ST_SEND;
      sreg      <= head;
      idx       <= '0;
      tx_data_q <= pick(head);
    end else if (accept) begin
      if (last_byte) begin
        state <= ST_IDLE;
      end else begin
        idx       <= idx + 1'b1;
        sreg      <= sreg_shifted;
        tx_data_q <= pick(sreg_shifted);
      end
    end
  end

endmodule
